// File: rtl/mtx_pkg.sv
// Shared types and constants for the Manchester transmitter: FSM state and
// half-bit phase enums, the preamble byte and the bit-counter width.
package mtx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    EOF      = 2'd3
  } mtx_state_t;

  typedef enum logic {
    FIRSTHALF  = 1'b0,
    SECONDHALF = 1'b1
  } mtx_phase_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;

  // Wide enough for the longest run counted in one state (15 preamble bytes).
  localparam int              CNT_W    = 7;
  localparam logic [CNT_W-1:0] CNT_ZERO = 7'd0;
  localparam logic [CNT_W-1:0] CNT_ONE  = 7'd1;

  function automatic logic preamble_bit(input logic [2:0] idx);
    return PREAMBLE_BYTE[idx];
  endfunction

endpackage

// File: rtl/clkenb.sv
// Clock-enable generator: one-cycle pulse on en every CLKFREQ/DIVFREQ clk cycles.
module clkenb #(
  parameter int CLKFREQ = 100_000_000,
  parameter int DIVFREQ = 19_200
) (
  input  logic clk,
  input  logic rst,
  output logic en
);

  localparam int DIV = CLKFREQ / DIVFREQ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CW{1'b0}};
      en  <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= {CW{1'b0}};
      en  <= 1'b1;
    end else begin
      cnt <= cnt + ONE;
      en  <= 1'b0;
    end
  end

endmodule

// File: rtl/manchester_tx.sv
// Manchester transmitter with inline word FIFO, framed as preamble / data / EOF.
// Optional preamble is built only when macro MTX_PREAMBLE_EN is defined.
module manchester_tx
  import mtx_pkg::*;
#(
  parameter int CLKFREQ        = 100_000_000,
  parameter int BAUD           = 9600,
  parameter int W              = 8,
  parameter int DEPTH          = 4,
  parameter int PREAMBLE_BYTES = 2,
  parameter int EOF_BITS       = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] data,
  input  logic         send,
  output logic         txd,
  output logic         txen,
  output logic         rdy,
  output logic         busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      FULL      = (AW + 1)'(DEPTH);
  localparam logic [AW:0]      CNT0      = {(AW + 1){1'b0}};
  localparam logic [AW:0]      CNT1      = (AW + 1)'(1);
  localparam logic [AW-1:0]    PTR1      = AW'(1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] EOF_LAST  = CNT_W'(EOF_BITS - 1);
`ifdef MTX_PREAMBLE_EN
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_BYTES * 8 - 1);
`endif

  if ((CLKFREQ / (2 * BAUD)) < 2 || (CLKFREQ % (2 * BAUD)) != 0) begin : g_bad_baud
    $error("manchester_tx: CLKFREQ/(2*BAUD) must be an integer >= 2");
  end
  if (W < 1 || W > 32) begin : g_bad_w
    $error("manchester_tx: W must be 1..32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("manchester_tx: DEPTH must be a power of two >= 2");
  end
  if (PREAMBLE_BYTES < 1 || PREAMBLE_BYTES > 15) begin : g_bad_pre
    $error("manchester_tx: PREAMBLE_BYTES must be 1..15");
  end
  if (EOF_BITS < 1 || EOF_BITS > 7) begin : g_bad_eof
    $error("manchester_tx: EOF_BITS must be 1..7");
  end

  logic hb;

  clkenb #(
    .CLKFREQ (CLKFREQ),
    .DIVFREQ (2 * BAUD)
  ) u_clkenb (
    .clk (clk),
    .rst (rst),
    .en  (hb)
  );

  // ---------------- FIFO ----------------
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          empty;
  logic [W-1:0]  head;

  assign rdy   = (count != FULL);
  assign empty = (count == CNT0);
  assign push  = send & rdy;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= CNT0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT1;
        2'b01:   count <= count - CNT1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- framing FSM ----------------
  mtx_state_t       state, state_nx;
  mtx_phase_t       phase, phase_nx;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic [W-1:0]     shreg, shreg_nx;
  logic             txd_nx, txen_nx;
  logic             cur_bit;
  logic             load_word;
  logic             go_eof;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= FIRSTHALF;
      bit_cnt <= CNT_ZERO;
      shreg   <= {W{1'b0}};
      txd     <= 1'b1;
      txen    <= 1'b0;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      bit_cnt <= bit_cnt_nx;
      shreg   <= shreg_nx;
      txd     <= txd_nx;
      txen    <= txen_nx;
    end
  end

  always_comb begin
    cur_bit = 1'b1;
    case (state)
`ifdef MTX_PREAMBLE_EN
      PREAMBLE: cur_bit = preamble_bit(bit_cnt[2:0]);
`endif
      DATA:     cur_bit = shreg[0];
      default:  cur_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_nx   = state;
    phase_nx   = phase;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    txd_nx     = txd;
    txen_nx    = txen;
    pop        = 1'b0;
    load_word  = 1'b0;
    go_eof     = 1'b0;

    if (!hb) begin
      pop = 1'b0;
    end else if (state != IDLE && phase == FIRSTHALF) begin
      // Second half-bit carries the true bit value.
      phase_nx = SECONDHALF;
      txd_nx   = cur_bit;
    end else begin
      // Bit boundary: choose the first half of the next bit.
      phase_nx = FIRSTHALF;
      case (state)
        IDLE: begin
          if (!empty) begin
            txen_nx    = 1'b1;
            bit_cnt_nx = CNT_ZERO;
`ifdef MTX_PREAMBLE_EN
            state_nx   = PREAMBLE;
            txd_nx     = ~preamble_bit(3'd0);
`else
            load_word  = 1'b1;
`endif
          end else begin
            txd_nx  = 1'b1;
            txen_nx = 1'b0;
          end
        end
`ifdef MTX_PREAMBLE_EN
        PREAMBLE: begin
          if (bit_cnt == PRE_LAST) begin
            load_word = !empty;
            go_eof    = empty;
          end else begin
            bit_cnt_nx = bit_cnt + CNT_ONE;
            txd_nx     = ~preamble_bit(bit_cnt_nx[2:0]);
          end
        end
`endif
        DATA: begin
          if (bit_cnt == DATA_LAST) begin
            load_word = !empty;
            go_eof    = empty;
          end else begin
            bit_cnt_nx = bit_cnt + CNT_ONE;
            shreg_nx   = shreg >> 1;
            txd_nx     = ~shreg_nx[0];
          end
        end
        EOF: begin
          if (bit_cnt == EOF_LAST) begin
            state_nx   = IDLE;
            bit_cnt_nx = CNT_ZERO;
            txd_nx     = 1'b1;
            txen_nx    = 1'b0;
          end else begin
            bit_cnt_nx = bit_cnt + CNT_ONE;
            txd_nx     = 1'b1;
          end
        end
        default: begin
          state_nx   = IDLE;
          bit_cnt_nx = CNT_ZERO;
          txd_nx     = 1'b1;
          txen_nx    = 1'b0;
        end
      endcase
    end

    // Both paths into a word are gated on a non-empty FIFO, so pop never underflows.
    if (load_word) begin
      pop        = 1'b1;
      state_nx   = DATA;
      shreg_nx   = head;
      bit_cnt_nx = CNT_ZERO;
      txd_nx     = ~head[0];
    end else if (go_eof) begin
      state_nx   = EOF;
      bit_cnt_nx = CNT_ZERO;
      txd_nx     = 1'b1;
    end else begin
      load_word = 1'b0;
    end
  end

endmodule

// File: tb/tb_manchester_tx.sv
// Scoreboard bench for manchester_tx: stimulus queues expected frames, a line
// monitor decodes each txen frame by half-bits and compares against the model.
module tb_manchester_tx;

  localparam int HALF     = 50;
  localparam int W        = 8;
  localparam int EOF_BITS = 2;
`ifdef MTX_PREAMBLE_EN
  localparam int PRE_BITS = 16;
`else
  localparam int PRE_BITS = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data;
  logic         send;
  logic         txd, txen, rdy, busy;

  int checks = 0;
  int errors = 0;
  bit abort  = 1'b0;

  logic [W-1:0] word_q[$];
  int           nwords_q[$];

  manchester_tx #(
    .CLKFREQ        (100_000_000),
    .BAUD           (1_000_000),
    .W              (W),
    .DEPTH          (4),
    .PREAMBLE_BYTES (2),
    .EOF_BITS       (EOF_BITS)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .send (send),
    .txd  (txd),
    .txen (txen),
    .rdy  (rdy),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic wait_txen(input logic val, input int budget, input string name, output int n);
    n = 0;
    while (txen !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, txen}, {31'd0, val});
  endtask

  task automatic push_word(input logic [W-1:0] w);
    data = w;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_txd"},  {31'd0, txd},  32'd1);
    chk({tag, "_txen"}, {31'd0, txen}, 32'd0);
    chk({tag, "_rdy"},  {31'd0, rdy},  32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Line monitor: decode every txen-high frame and compare with the scoreboard.
  initial begin : monitor
    int           cyc;
    int           n;
    int           bad;
    bit           got_h[$];
    bit           exp_h[$];
    logic [W-1:0] w;
    forever begin
      @(negedge clk);
      if (txen === 1'b1) begin
        cyc = 0;
        got_h.delete();
        while (txen === 1'b1) begin
          if (cyc % HALF == HALF / 2) got_h.push_back(txd);
          cyc++;
          @(negedge clk);
        end
        if (!abort) begin
          if (nwords_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
          end else begin
            n = nwords_q.pop_front();
            exp_h.delete();
            for (int i = 0; i < PRE_BITS; i++) begin
              exp_h.push_back(i % 2 != 0);
              exp_h.push_back(i % 2 == 0);
            end
            for (int k = 0; k < n; k++) begin
              w = word_q.pop_front();
              for (int j = 0; j < W; j++) begin
                exp_h.push_back(!w[j]);
                exp_h.push_back(w[j]);
              end
            end
            for (int i = 0; i < 2 * EOF_BITS; i++) exp_h.push_back(1'b1);
            chk("frame_len_clk", cyc, exp_h.size() * HALF);
            bad = -1;
            for (int i = 0; i < exp_h.size(); i++) begin
              if (bad < 0 && (i >= got_h.size() || got_h[i] != exp_h[i])) bad = i;
            end
            chk("frame_first_bad_halfbit", bad, -1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int           n;
    int           cnt;
    int           nb;
    bit           ok;
    logic [W-1:0] w;
    rst  = 1'b1;
    send = 1'b0;
    data = '0;

    // Reset held for three edges; outputs idle after each.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_idle_outputs("reset");
    end
    rst = 1'b0;

    // Five back-to-back pushes into a 4-deep FIFO: the fifth is dropped.
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      w = W'($urandom);
      chk("burst_rdy", {31'd0, rdy}, (cnt < 4) ? 32'd1 : 32'd0);
      if (cnt < 4) begin
        word_q.push_back(w);
        cnt++;
      end
      push_word(w);
    end
    chk("full_rdy", {31'd0, rdy}, 32'd0);
    nwords_q.push_back(4);
    wait_txen(1'b1, 200, "burst_start", n);
    wait_txen(1'b0, 6000, "burst_end", n);

    // Single word 8'hA5 with start latency bound.
    word_q.push_back(8'hA5);
    nwords_q.push_back(1);
    push_word(8'hA5);
    wait_txen(1'b1, 200, "a5_start", n);
    chk("a5_latency_ok", {31'd0, n <= 52}, 32'd1);
    wait_txen(1'b0, 6000, "a5_end", n);

    // Word pushed during EOF becomes its own frame after an idle gap.
    w = W'($urandom);
    word_q.push_back(w);
    nwords_q.push_back(1);
    push_word(w);
    wait_txen(1'b1, 200, "eofpush_start", n);
    repeat ((PRE_BITS + W) * 2 * HALF + 60) @(negedge clk);
    chk("eof_busy", {31'd0, busy}, 32'd1);
    chk("eof_txd", {31'd0, txd}, 32'd1);
    chk("eof_rdy", {31'd0, rdy}, 32'd1);
    word_q.push_back(8'h3C);
    nwords_q.push_back(1);
    push_word(8'h3C);
    wait_txen(1'b0, 300, "eofpush_end1", n);
    wait_txen(1'b1, 200, "eofpush_start2", n);
    chk("eof_gap_ok", {31'd0, n >= 1}, 32'd1);
    wait_txen(1'b0, 6000, "eofpush_end2", n);

    // Random bursts, each issued just after a frame ends so it forms one frame.
    for (int r = 0; r < 5; r++) begin
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        w = W'($urandom);
        word_q.push_back(w);
        push_word(w);
      end
      nwords_q.push_back(nb);
      wait_txen(1'b1, 200, "rand_start", n);
      wait_txen(1'b0, 6000, "rand_end", n);
    end

    // Reset during data bit 3 of 8'hFF: line goes idle immediately and stays idle.
    word_q.push_back(8'hFF);
    nwords_q.push_back(1);
    push_word(8'hFF);
    wait_txen(1'b1, 200, "rstmid_start", n);
    repeat ((PRE_BITS + 3) * 2 * HALF + HALF) @(negedge clk);
    abort = 1'b1;
    word_q.delete();
    nwords_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("rstmid");
    rst = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (txen !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    chk("rstmid_idle_1000", {31'd0, ok}, 32'd1);
    abort = 1'b0;

    // Fresh frame after reset: one word only, so nothing survived in the FIFO.
    word_q.push_back(8'h0F);
    nwords_q.push_back(1);
    push_word(8'h0F);
    wait_txen(1'b1, 200, "post_rst_start", n);
    wait_txen(1'b0, 6000, "post_rst_end", n);

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", nwords_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/manchester_tx.md
MANCHESTER_TX -- requirements
Module: manchester_tx

Interface
REQ-001 Parameter CLKFREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, bit rate in bit/s; CLKFREQ/(2*BAUD) SHALL be an integer >= 2.
REQ-003 Parameter W, default 8, data word width in bits, range 1..32.
REQ-004 Parameter DEPTH, default 4, input FIFO depth in words; power of two, >= 2.
REQ-005 Parameter PREAMBLE_BYTES, default 2, number of 8-bit preamble bytes per frame, range 1..15.
REQ-006 Parameter EOF_BITS, default 2, end-of-frame bit times, range 1..7.
REQ-007 clk  input  1  system clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 data  input  W  word to transmit, LSB first.
REQ-010 send  input  1  write strobe; data is pushed into the FIFO on any clk edge with send=1 and rdy=1.
REQ-011 txd  output  1  Manchester-encoded serial line, registered.
REQ-012 txen  output  1  line-driver enable, registered; high for the whole frame including EOF.
REQ-013 rdy  output  1  FIFO not full.
REQ-014 busy  output  1  FSM not in IDLE.

Function
REQ-015 Half-bit tick (hb) SHALL pulse for one clk every CLKFREQ/(2*BAUD) cycles; the FSM and txd update only on hb.
REQ-016 Encoding per bit b: first half-bit txd = ~b, second half-bit txd = b (1 = low-to-high mid-bit, 0 = high-to-low).
REQ-017 FSM states: IDLE, PREAMBLE, DATA, EOF.
REQ-018 IDLE: txd=1, txen=0; on the first hb with FIFO non-empty, go to PREAMBLE (or DATA, see REQ-030).
REQ-019 PREAMBLE: sends PREAMBLE_BYTES*8 bits of 8'h55, LSB first (1,0,1,0,...), then goes to DATA.
REQ-020 DATA: pops one word at its first half-bit and sends W bits LSB first; at the end of the last bit, if the FIFO is non-empty, the next word follows with no gap; otherwise the FSM goes to EOF.
REQ-021 EOF: txd=1, txen=1 for EOF_BITS bit times, then IDLE.
REQ-022 Words pushed during EOF SHALL wait for IDLE and start a new frame with preamble.
REQ-023 send with rdy=0 SHALL be ignored and the word dropped.
REQ-024 Push and pop on the same cycle SHALL both complete; rdy is computed from registered occupancy, so a full FIFO rejects a push even when a pop occurs on that cycle.
REQ-025 The FIFO SHALL never be popped when empty.
REQ-026 Pointers SHALL wrap modulo DEPTH; occupancy SHALL have log2(DEPTH)+1 bits.
REQ-027 Latency from an accepted send in IDLE to the first txen=1: at most CLKFREQ/(2*BAUD)+2 clk cycles.

Reset
REQ-028 On rst=1 (including mid-frame): next edge txd=1, txen=0, rdy=1, busy=0; state IDLE; FIFO flushed; half-bit divider, bit counter and phase cleared.
REQ-029 No partial word or EOF SHALL be emitted after reset; the next frame starts from preamble.

Configuration
REQ-030 Macro MTX_PREAMBLE_EN: if defined, the PREAMBLE state is built and used per REQ-019; if undefined, PREAMBLE logic is omitted, PREAMBLE_BYTES is ignored, and IDLE goes directly to DATA.

Structure
REQ-031 Package mtx_pkg SHALL hold the state enum type (mtx_state_t), the preamble byte constant (8'h55) and the phase enum (FIRSTHALF/SECONDHALF).
REQ-032 The half-bit tick SHALL come from the existing clkenb sub-module with DIVFREQ=2*BAUD; the FIFO is inline.

Verification (CLKFREQ=100e6, BAUD=1e6: 50 clk per half-bit, 100 per bit)
REQ-033 Apply rst for 3 cycles -> txd=1, txen=0, rdy=1, busy=0 on every cycle after the first edge.
REQ-034 MTX_PREAMBLE_EN defined, PREAMBLE_BYTES=2, push 8'hA5 -> txen high for 26 bit times (2600 clk); decoded line shows 16 preamble bits 1010..., then data 1,0,1,0,0,1,0,1, then 2 bit times at txd=1.
REQ-035 Push 5 words back-to-back while idle (DEPTH=4) -> rdy low after the 4th push, 5th word dropped; 4 words sent contiguously with no gap between word boundaries.
REQ-036 rst asserted during data bit 3 of 8'hFF -> next cycle txd=1, txen=0, rdy=1, FIFO empty; line stays idle for 1000 clk.
REQ-037 MTX_PREAMBLE_EN undefined, push 8'h0F -> frame is 10 bit times; first half-bit txd=0; decoded bits 1,1,1,1,0,0,0,0.
REQ-038 Push 8'h3C during EOF of a prior frame -> EOF completes (txd=1 for 200 clk), txen drops for at least 1 clk, then a new frame starts with preamble.
